// File: rtl/proc_pkg.sv
// Shared definitions for the proc_ctrl instruction sequencer: opcodes,
// datapath select codes, ALU operation codes and the controller state type.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;

  // mux_sel codes 0-7 address R0-R7 directly
  localparam logic [3:0] SEL_IMD = 4'd8;
  localparam logic [3:0] SEL_G   = 4'd9;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
  } instr_t;

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_dec3to8.sv
// One-hot register write-enable decoder: bit sel_i of onehot_o is set when en_i.
module proc_dec3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle instruction sequencer for a small register-file datapath.
// Define PROC_CTRL_LOGIC_EN to enable the and/xor opcodes (100/101).
module proc_ctrl
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [8:0]        ir_in,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        mux_sel,
  output logic [7:0]        reg_load,
  output logic              a_load,
  output logic              g_load,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] instr_cnt
);

`ifdef PROC_CTRL_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  instr_t              ir_q, ir_d;
  logic [DATA_W-1:0]   cnt_q, cnt_d;
  logic                ld_en;
  logic                three_step;

  assign three_step = (ir_q.op == OP_ADD) || (ir_q.op == OP_SUB) ||
                      (LOGIC_EN && ((ir_q.op == OP_AND) || (ir_q.op == OP_XOR)));

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned (no latches).
    state_d = state_q;
    ir_d    = ir_q;
    mux_sel = 4'd0;
    ld_en   = 1'b0;
    a_load  = 1'b0;
    g_load  = 1'b0;
    alu_op  = ALU_ADD;
    done    = 1'b0;
    illegal = 1'b0;

    case (state_q)
      IDLE: begin
        if (run) begin
          ir_d    = instr_t'(ir_in);
          state_d = T1;
        end
      end
      T1: begin
        state_d = IDLE;
        if (ir_q.op == OP_MV) begin
          mux_sel = {1'b0, ir_q.y};
          ld_en   = 1'b1;
          done    = 1'b1;
        end else if (ir_q.op == OP_MVI) begin
          mux_sel = SEL_IMD;
          ld_en   = 1'b1;
          done    = 1'b1;
        end else if (three_step) begin
          mux_sel = {1'b0, ir_q.x};
          a_load  = 1'b1;
          state_d = T2;
        end else begin
          done    = 1'b1;
          illegal = 1'b1;
        end
      end
      T2: begin
        mux_sel = {1'b0, ir_q.y};
        g_load  = 1'b1;
        alu_op  = alu_code(ir_q.op);
        state_d = T3;
      end
      T3: begin
        mux_sel = SEL_G;
        ld_en   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cnt_d = (done && !illegal) ? cnt_q + DATA_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together from pre-edge values.
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode the registered state, so reset clears them without a clock edge.
  assign busy      = (state_q != IDLE);
  assign instr_cnt = cnt_q;

  proc_dec3to8 u_dec (
    .sel_i    (ir_q.x),
    .en_i     (ld_en),
    .onehot_o (reg_load)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: per-instruction cycle expectations come
// from a behavioural model of the instruction set; counter uses a narrow DATA_W.
module tb_proc_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic [8:0]    ir_in;
  logic          busy, done, illegal, a_load, g_load;
  logic [3:0]    mux_sel;
  logic [7:0]    reg_load;
  logic [1:0]    alu_op;
  logic [DW-1:0] instr_cnt;

  int n_checks  = 0;
  int n_pass    = 0;
  int exp_cnt   = 0;
  int done_seen = 0;

  typedef struct packed {
    logic [3:0] mux_sel;
    logic [7:0] reg_load;
    logic       a_load;
    logic       g_load;
    logic [1:0] alu_op;
    logic       done;
    logic       illegal;
    logic       busy;
  } obs_t;

`ifdef PROC_CTRL_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  proc_ctrl #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .ir_in     (ir_in),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .mux_sel   (mux_sel),
    .reg_load  (reg_load),
    .a_load    (a_load),
    .g_load    (g_load),
    .alu_op    (alu_op),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  function automatic obs_t observed();
    obs_t o;
    o.mux_sel  = mux_sel;
    o.reg_load = reg_load;
    o.a_load   = a_load;
    o.g_load   = g_load;
    o.alu_op   = alu_op;
    o.done     = done;
    o.illegal  = illegal;
    o.busy     = busy;
    return o;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit is_alu(input int op);
    return (op == 2) || (op == 3) || (LOGIC_EN && (op == 4 || op == 5));
  endfunction

  function automatic bit is_legal(input logic [8:0] ir);
    int op = int'(ir[8:6]);
    return (op <= 1) || is_alu(op);
  endfunction

  function automatic int n_cyc(input logic [8:0] ir);
    return is_alu(int'(ir[8:6])) ? 3 : 1;
  endfunction

  // Expected outputs in cycle k (0 = T1) of instruction ir.
  function automatic obs_t exp_at(input logic [8:0] ir, input int k);
    obs_t e = '0;
    int op = int'(ir[8:6]);
    int x  = int'(ir[5:3]);
    int y  = int'(ir[2:0]);
    e.busy = 1'b1;
    if (op == 0) begin
      e.mux_sel = 4'(y); e.reg_load = 8'(1 << x); e.done = 1'b1;
    end else if (op == 1) begin
      e.mux_sel = 4'd8; e.reg_load = 8'(1 << x); e.done = 1'b1;
    end else if (is_alu(op)) begin
      if (k == 0) begin
        e.mux_sel = 4'(x); e.a_load = 1'b1;
      end else if (k == 1) begin
        e.mux_sel = 4'(y); e.g_load = 1'b1; e.alu_op = 2'(op - 2);
      end else begin
        e.mux_sel = 4'd9; e.reg_load = 8'(1 << x); e.done = 1'b1;
      end
    end else begin
      e.done = 1'b1; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // ---------------- scenario helpers ----------------
  task automatic idle_check(input string tag);
    @(negedge clk);
    n_checks++;
    if ({observed(), instr_cnt} !== {19'b0, DW'(exp_cnt)})
      $display("FAIL %s idle: outputs=%h cnt=%0d, expected outputs=0 cnt=%0d",
               tag, observed(), instr_cnt, exp_cnt);
    else n_pass++;
  endtask

  // Issue ir from IDLE and check every busy cycle; with hold, run stays high
  // carrying next_ir so it must be ignored until the controller returns to IDLE.
  task automatic exec(input logic [8:0] ir, input bit hold, input logic [8:0] next_ir,
                      input string tag);
    obs_t e;
    idle_check(tag);
    run   = 1'b1;
    ir_in = ir;
    for (int k = 0; k < n_cyc(ir); k++) begin
      @(negedge clk);
      if (hold) ir_in = next_ir;
      else begin
        run   = 1'b0;
        ir_in = 9'($urandom);
      end
      e = exp_at(ir, k);
      n_checks++;
      if (observed() !== e)
        $display("FAIL %s ir=%b cycle %0d: got %h, expected %h", tag, ir, k, observed(), e);
      else n_pass++;
    end
    if (is_legal(ir)) exp_cnt = (exp_cnt + 1) % (1 << DW);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    ir_in = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({observed(), instr_cnt} !== '0)
      $display("FAIL reset: outputs=%h cnt=%0d, expected all 0", observed(), instr_cnt);
    else n_pass++;
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_mvi();
    exec(9'b001_010_000, 1'b0, '0, "mvi");
    idle_check("mvi_cnt");
  endtask

  task automatic test_add_sub();
    exec(9'b010_001_010, 1'b0, '0, "add");
    exec(9'b011_111_000, 1'b0, '0, "sub");
    exec(9'b010_011_011, 1'b0, '0, "add_xeqy");
    exec(9'b000_100_110, 1'b0, '0, "mv");
  endtask

  task automatic test_illegal();
    exec(9'b110_001_010, 1'b0, '0, "op110");
    exec(9'b100_010_011, 1'b0, '0, "op100");
    exec(9'b101_110_001, 1'b0, '0, "op101");
    exec(9'b111_000_111, 1'b0, '0, "op111");
    idle_check("illegal_cnt");
  endtask

  task automatic test_back_to_back();
    int d0 = done_seen;
    exec(9'b011_010_101, 1'b1, 9'b000_011_010, "b2b_sub");
    exec(9'b000_011_010, 1'b0, '0, "b2b_mv");
    idle_check("b2b_end");
    n_checks++;
    if (done_seen - d0 !== 2)
      $display("FAIL b2b_done_count: got %0d, expected 2", done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    run   = 1'b1;
    ir_in = 9'b010_101_110;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    n_checks++;
    if (g_load !== 1'b1) $display("FAIL rst_mid_t2: g_load=%b, expected 1", g_load);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({observed(), instr_cnt} !== '0)
      $display("FAIL rst_mid_async: outputs=%h cnt=%0d, expected all 0", observed(), instr_cnt);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({observed(), instr_cnt} !== '0)
      $display("FAIL rst_mid_hold: outputs=%h cnt=%0d, expected all 0", observed(), instr_cnt);
    else n_pass++;
    rst_n   = 1'b1;
    exp_cnt = 0;
    exec(9'b000_110_101, 1'b0, '0, "rst_mid_mv");
    idle_check("rst_mid_end");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      exec(9'($urandom), 1'b0, '0, "rand");
    end
    idle_check("rand_end");
  endtask

  task automatic test_wrap();
    while (exp_cnt != (1 << DW) - 1) begin
      exec({3'b000, 6'($urandom)}, 1'b0, '0, "wrap_fill");
    end
    idle_check("wrap_full");
    exec(9'b001_111_000, 1'b0, '0, "wrap_last");
    idle_check("wrap_zero");
  endtask

  initial begin
    test_reset();
    test_mvi();
    test_add_sub();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
